// File: rtl/adder_pkg.sv
// Shared sizing helpers for the adder arbiter: requester-ID width and
// signed saturation limits for a given data width.
package adder_pkg;

  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Limits are returned zero-extended in 64 bits; callers slice to their width.
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/adder.sv
// Fixed-point two's complement adder: wrapped sum plus signed overflow and
// underflow flags. The carry is split at the binary point.
module adder #(
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  ovf,
  output logic                  unf
);

  if (FIXED_PNT > 0 && FIXED_PNT < DATA_WIDTH) begin : g_split
    logic [FIXED_PNT:0]              frac;
    logic [DATA_WIDTH-FIXED_PNT-1:0] int_part;

    assign frac     = {1'b0, a[FIXED_PNT-1:0]} + {1'b0, b[FIXED_PNT-1:0]};
    assign int_part = a[DATA_WIDTH-1:FIXED_PNT] + b[DATA_WIDTH-1:FIXED_PNT]
                      + (DATA_WIDTH-FIXED_PNT)'(frac[FIXED_PNT]);
    assign sum      = {int_part, frac[FIXED_PNT-1:0]};
  end else begin : g_flat
    assign sum = a + b;
  end

  // Signed overflow only when both operands share a sign the sum lost.
  assign ovf = ~a[DATA_WIDTH-1] & ~b[DATA_WIDTH-1] &  sum[DATA_WIDTH-1];
  assign unf =  a[DATA_WIDTH-1] &  b[DATA_WIDTH-1] & ~sum[DATA_WIDTH-1];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among N_REQ valid/ready requesters, with a
// back-pressurable result register, optional saturation and a flag counter.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8,
  parameter int N_REQ      = 4,
  parameter int SATURATE   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_sum,
  output logic [id_width(N_REQ)-1:0]    out_id,
  output logic                          out_ovf,
  output logic                          out_unf,
  input  logic                          clr_count,
  output logic [CNT_WIDTH-1:0]          flag_count
);

  localparam int ID_W = id_width(N_REQ);
  localparam logic [63:0] SAT_MAX_W = sat_max(DATA_WIDTH);
  localparam logic [63:0] SAT_MIN_W = sat_min(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = SAT_MAX_W[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = SAT_MIN_W[DATA_WIDTH-1:0];

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_unf_q, out_unf_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  flag_count_q, flag_count_d;

  logic                  out_free;
  logic                  found;
  logic                  accept;
  logic [ID_W-1:0]       grant_idx;
  logic [N_REQ-1:0]      grant;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_ovf, add_unf;
  int                    idx;

  // Search upward from rr_ptr with wrap; N_REQ need not be a power of two.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    op_a      = '0;
    op_b      = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = found && (grant_idx == ID_W'(i));
      if (grant[i]) begin
        op_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        op_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_free  = !out_valid_q || out_ready;
  assign req_ready = out_free ? grant : '0;
  assign accept    = found && out_free;

  adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIXED_PNT  (FIXED_PNT)
  ) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum),
    .ovf (add_ovf),
    .unf (add_unf)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_id_d     = out_id_q;
    out_ovf_d    = out_ovf_q;
    out_unf_d    = out_unf_q;
    rr_ptr_d     = rr_ptr_q;
    flag_count_d = flag_count_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_id_d    = grant_idx;
      out_ovf_d   = add_ovf;
      out_unf_d   = add_unf;
      if (SATURATE != 0 && add_ovf)      out_sum_d = SAT_MAX;
      else if (SATURATE != 0 && add_unf) out_sum_d = SAT_MIN;
      else                               out_sum_d = add_sum;
      rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    if (clr_count)
      flag_count_d = '0;
    else if (accept && (add_ovf || add_unf) && (flag_count_q != '1))
      flag_count_d = flag_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_id_q     <= '0;
      out_ovf_q    <= 1'b0;
      out_unf_q    <= 1'b0;
      rr_ptr_q     <= '0;
      flag_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_id_q     <= out_id_d;
      out_ovf_q    <= out_ovf_d;
      out_unf_q    <= out_unf_d;
      rr_ptr_q     <= rr_ptr_d;
      flag_count_q <= flag_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_id     = out_id_q;
  assign out_ovf    = out_ovf_q;
  assign out_unf    = out_unf_q;
  assign flag_count = flag_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a saturating instance and a wrapping
// instance with a 2-bit counter are driven in lockstep and checked together.
module tb_adder_arbiter;

  localparam int DW  = 16;
  localparam int NR  = 4;
  localparam int CW  = 16;
  localparam int WCW = 2;
  localparam logic [63:0] A_ALL = 64'h0004_0003_0002_0001;
  localparam logic [63:0] B_ALL = 64'h0040_0030_0020_0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_a = '0, req_b = '0;
  logic             out_ready = 1'b0, clr_count = 1'b0;

  logic [NR-1:0] s_ready, w_ready;
  logic          s_valid, w_valid, s_ovf, w_ovf, s_unf, w_unf;
  logic [DW-1:0] s_sum, w_sum;
  logic [1:0]    s_id, w_id;
  logic [CW-1:0] s_cnt;
  logic [WCW-1:0] w_cnt;

  adder_arbiter #(.DATA_WIDTH(DW), .FIXED_PNT(8), .N_REQ(NR), .SATURATE(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_ready),
    .req_a(req_a), .req_b(req_b), .out_valid(s_valid), .out_ready(out_ready),
    .out_sum(s_sum), .out_id(s_id), .out_ovf(s_ovf), .out_unf(s_unf),
    .clr_count(clr_count), .flag_count(s_cnt));

  adder_arbiter #(.DATA_WIDTH(DW), .FIXED_PNT(8), .N_REQ(NR), .SATURATE(0), .CNT_WIDTH(WCW)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w_ready),
    .req_a(req_a), .req_b(req_b), .out_valid(w_valid), .out_ready(out_ready),
    .out_sum(w_sum), .out_id(w_id), .out_ovf(w_ovf), .out_unf(w_unf),
    .clr_count(clr_count), .flag_count(w_cnt));

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: integer arithmetic on the requester's operands.
  logic          m_valid, m_ovf, m_unf;
  logic [DW-1:0] m_sum, m_wsum;
  int            m_id, m_rr, m_cnt, m_wcnt;
  logic [NR-1:0] mdl_ready, seen_ready_s, seen_ready_w;

  typedef struct {
    logic [3:0]  v;
    logic [63:0] a;
    logic [63:0] b;
    logic        ordy;
    logic        clr;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [15:0] exp_sum;
    logic [15:0] exp_wsum;
    int          exp_id;
    logic        exp_ovf;
    logic        exp_unf;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic modelReset();
    m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_sum = '0; m_wsum = '0; m_id = 0; m_rr = 0; m_cnt = 0; m_wcnt = 0;
  endtask

  function automatic int mdlGrant(input logic [3:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, samples req_ready before the edge, then
  // advances the model across the edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                               input logic ordy, input logic clr);
    int g;
    logic free;
    logic signed [15:0] sa, sb;
    int s;
    req_valid = v; req_a = a; req_b = b; out_ready = ordy; clr_count = clr;
    #1;
    g = mdlGrant(v);
    free = !m_valid || ordy;
    mdl_ready = (free && g >= 0) ? 4'(1 << g) : 4'b0000;
    seen_ready_s = s_ready;
    seen_ready_w = w_ready;
    @(posedge clk);
    #1;
    if (free && g >= 0) begin
      sa = a[g*16 +: 16];
      sb = b[g*16 +: 16];
      s = int'(sa) + int'(sb);
      m_ovf = (s > 32767);
      m_unf = (s < -32768);
      m_wsum = 16'(s);
      m_sum = m_ovf ? 16'h7FFF : (m_unf ? 16'h8000 : m_wsum);
      m_id = g;
      m_valid = 1'b1;
      m_rr = (g + 1) % NR;
      if (m_ovf || m_unf) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_wcnt < (1 << WCW) - 1) m_wcnt++;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (clr) begin
      m_cnt = 0;
      m_wcnt = 0;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b0; clr_count = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'b0001, 64'h0000_0000_0000_0180, 64'h0000_0000_0000_0240, 1'b1, 1'b0,
                4'b0001, 1'b1, 16'h03C0, 16'h03C0, 0, 1'b0, 1'b0, 0};
    vecs[1] = '{4'b0100, 64'h0000_7000_0000_0000, 64'h0000_2000_0000_0000, 1'b1, 1'b0,
                4'b0100, 1'b1, 16'h7FFF, 16'h9000, 2, 1'b1, 1'b0, 1};
    vecs[2] = '{4'b1000, 64'h8000_0000_0000_0000, 64'hFFFF_0000_0000_0000, 1'b1, 1'b0,
                4'b1000, 1'b1, 16'h8000, 16'h7FFF, 3, 1'b0, 1'b1, 2};
    vecs[3] = '{4'b0000, 64'h0, 64'h0, 1'b1, 1'b0,
                4'b0000, 1'b0, 16'h8000, 16'h7FFF, 3, 1'b0, 1'b1, 2};
    vecs[4] = '{4'b0010, 64'h0000_0000_7FFF_0000, 64'h0, 1'b1, 1'b0,
                4'b0010, 1'b1, 16'h7FFF, 16'h7FFF, 1, 1'b0, 1'b0, 2};
    vecs[5] = '{4'b0001, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0,
                4'b0001, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 2};

    doReset();
    checkOutput("rst_valid", 32'(s_valid), 32'd0);
    checkOutput("rst_sum", 32'(s_sum), 32'd0);
    checkOutput("rst_id", 32'(s_id), 32'd0);
    checkOutput("rst_flags", {30'd0, s_ovf, s_unf}, 32'd0);
    checkOutput("rst_cnt", 32'(s_cnt), 32'd0);
    checkOutput("rst_wvalid", 32'(w_valid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].ordy, vecs[i].clr);
      checkOutput($sformatf("vec%0d_ready", i), 32'(seen_ready_s), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_sum", i), 32'(s_sum), 32'(vecs[i].exp_sum));
      checkOutput($sformatf("vec%0d_wsum", i), 32'(w_sum), 32'(vecs[i].exp_wsum));
      checkOutput($sformatf("vec%0d_id", i), 32'(s_id), 32'(vecs[i].exp_id));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(s_ovf), 32'(vecs[i].exp_ovf));
      checkOutput($sformatf("vec%0d_unf", i), 32'(s_unf), 32'(vecs[i].exp_unf));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(s_cnt), 32'(vecs[i].exp_cnt));
    end

    // All requesters valid: strict rotation, one grant per cycle.
    doReset();
    for (int n = 0; n < 6; n++) begin
      applyStimulus(4'hF, A_ALL, B_ALL, 1'b1, 1'b0);
      checkOutput($sformatf("rot%0d_ready", n), 32'(seen_ready_s), 32'(1 << (n % 4)));
      checkOutput($sformatf("rot%0d_onehot", n), 32'($onehot(seen_ready_s)), 32'd1);
      checkOutput($sformatf("rot%0d_id", n), 32'(s_id), 32'(n % 4));
      checkOutput($sformatf("rot%0d_sum", n), 32'(s_sum), 32'(16'h11 * ((n % 4) + 1)));
    end

    // Back-pressure: outputs frozen, nothing accepted, then same-cycle drain+load.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(4'hF, A_ALL, B_ALL, 1'b0, 1'b0);
      checkOutput($sformatf("bp%0d_ready", n), 32'(seen_ready_s), 32'd0);
      checkOutput($sformatf("bp%0d_valid", n), 32'(s_valid), 32'd1);
      checkOutput($sformatf("bp%0d_id", n), 32'(s_id), 32'd1);
      checkOutput($sformatf("bp%0d_sum", n), 32'(s_sum), 32'h22);
    end
    applyStimulus(4'hF, A_ALL, B_ALL, 1'b1, 1'b0);
    checkOutput("bp_release_ready", 32'(seen_ready_s), 32'b0100);
    checkOutput("bp_release_valid", 32'(s_valid), 32'd1);
    checkOutput("bp_release_id", 32'(s_id), 32'd2);
    checkOutput("bp_release_sum", 32'(s_sum), 32'h33);

    // Overflow bumps the counter, then an async reset between edges clears it.
    applyStimulus(4'b0001, 64'h0000_0000_0000_7000, 64'h0000_0000_0000_2000, 1'b1, 1'b0);
    checkOutput("pre_rst_id", 32'(s_id), 32'd0);
    checkOutput("pre_rst_cnt", 32'(s_cnt), 32'd1);
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(s_valid), 32'd0);
    checkOutput("async_rst_cnt", 32'(s_cnt), 32'd0);
    checkOutput("async_rst_wcnt", 32'(w_cnt), 32'd0);
    #2 rst_n = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    applyStimulus(4'hF, A_ALL, B_ALL, 1'b1, 1'b0);
    checkOutput("post_rst_ready", 32'(seen_ready_s), 32'b0001);
    checkOutput("post_rst_id", 32'(s_id), 32'd0);
    applyStimulus(4'b0010, 64'h0000_0000_7000_0000, 64'h0000_0000_2000_0000, 1'b1, 1'b1);
    checkOutput("clr_ovf_ready", 32'(seen_ready_s), 32'b0010);
    checkOutput("clr_ovf_flag", 32'(s_ovf), 32'd1);
    checkOutput("clr_ovf_cnt", 32'(s_cnt), 32'd0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      applyStimulus(4'($urandom), ra, rb, ($urandom_range(9, 0) < 7), ($urandom_range(39, 0) == 0));
      checkOutput("rnd_ready", 32'(seen_ready_s), 32'(mdl_ready));
      checkOutput("rnd_wready", 32'(seen_ready_w), 32'(mdl_ready));
      checkOutput("rnd_valid", 32'(s_valid), 32'(m_valid));
      checkOutput("rnd_sum", 32'(s_sum), 32'(m_sum));
      checkOutput("rnd_wsum", 32'(w_sum), 32'(m_wsum));
      checkOutput("rnd_id", 32'(s_id), 32'(m_id));
      checkOutput("rnd_flags", {30'd0, s_ovf, s_unf}, {30'd0, m_ovf, m_unf});
      checkOutput("rnd_cnt", 32'(s_cnt), 32'(m_cnt));
      checkOutput("rnd_wcnt", 32'(w_cnt), 32'(m_wcnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
